// File: rtl/mmio_bus_pkg.sv
// Shared types and default address map for the MMIO bus bridge.
// Default map: data RAM, instruction ROM, GPIO and UART in slots 0..3.
package mmio_bus_pkg;

   localparam int MAX_SLAVES = 8;

   localparam logic [31:0] RAM_BASE  = 32'h1001_0000;
   localparam logic [31:0] RAM_MASK  = 32'hFFFF_FF00;
   localparam logic [31:0] ROM_BASE  = 32'h0040_0000;
   localparam logic [31:0] ROM_MASK  = 32'hFFFF_F000;
   localparam logic [31:0] GPIO_BASE = 32'h1001_0100;
   localparam logic [31:0] GPIO_MASK = 32'hFFFF_FFF0;
   localparam logic [31:0] UART_BASE = 32'h1001_0200;
   localparam logic [31:0] UART_MASK = 32'hFFFF_FFF0;

   localparam logic [127:0] DEF_BASE_ADDRS = {UART_BASE, GPIO_BASE, ROM_BASE, RAM_BASE};
   localparam logic [127:0] DEF_ADDR_MASKS = {UART_MASK, GPIO_MASK, ROM_MASK, RAM_MASK};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_RESP
   } state_t;

endpackage

// File: rtl/mmio_addr_decoder.sv
// Combinational base/mask address decoder; zero latency, no flow control.
// Lowest matching slot wins, yielding a one-hot hit vector plus a hit flag.
module mmio_addr_decoder
   import mmio_bus_pkg::*;
#(
   parameter int                         N_SLAVES   = 4,
   parameter int                         ADDR_W     = 32,
   parameter logic [N_SLAVES*ADDR_W-1:0] BASE_ADDRS = DEF_BASE_ADDRS,
   parameter logic [N_SLAVES*ADDR_W-1:0] ADDR_MASKS = DEF_ADDR_MASKS
) (
   input  logic [ADDR_W-1:0]   i_addr,
   output logic [N_SLAVES-1:0] o_hit_vec,
   output logic                o_hit
);

   always_comb begin
      o_hit_vec = '0;
      o_hit     = 1'b0;
      for (int i = 0; i < N_SLAVES; i++) begin
         if (!o_hit &&
             ((i_addr & ADDR_MASKS[i*ADDR_W +: ADDR_W]) == BASE_ADDRS[i*ADDR_W +: ADDR_W])) begin
            o_hit_vec[i] = 1'b1;
            o_hit        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mmio_bus_bridge.sv
// Core-to-peripheral MMIO bridge: IDLE->BUSY->RESP, response k+1 cycles after accept, 1 for unmapped.
// Stalls the core until rsp_valid; MMIO_BUS_TIMEOUT_EN adds a BUSY timeout returning err.
module mmio_bus_bridge
   import mmio_bus_pkg::*;
#(
   parameter int                         N_SLAVES       = 4,
   parameter int                         ADDR_W         = 32,
   parameter int                         DATA_W         = 32,
   parameter logic [N_SLAVES*ADDR_W-1:0] BASE_ADDRS     = DEF_BASE_ADDRS,
   parameter logic [N_SLAVES*ADDR_W-1:0] ADDR_MASKS     = DEF_ADDR_MASKS,
   parameter int                         TIMEOUT_CYCLES = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   input  logic                       req_we,
   input  logic [ADDR_W-1:0]          req_addr,
   input  logic [DATA_W-1:0]          req_wdata,
   output logic                       stall,
   output logic                       rsp_valid,
   output logic [DATA_W-1:0]          rsp_rdata,
   output logic                       rsp_err,
   output logic [N_SLAVES-1:0]        dev_sel,
   output logic                       dev_we,
   output logic [ADDR_W-1:0]          dev_addr,
   output logic [DATA_W-1:0]          dev_wdata,
   input  logic [N_SLAVES*DATA_W-1:0] dev_rdata,
   input  logic [N_SLAVES-1:0]        dev_ack
);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [N_SLAVES-1:0]   r_sel;
   logic                  r_we;
   logic [ADDR_W-1:0]     r_addr;
   logic [DATA_W-1:0]     r_wdata;
   logic [DATA_W-1:0]     r_rdata;
   logic                  r_err;
   logic [N_SLAVES-1:0]   w_hit_vec;
   logic                  w_hit;
   logic                  w_ack;
   logic                  w_tmo;
   logic                  w_accept;
   logic [DATA_W-1:0]     w_sel_rdata;

   mmio_addr_decoder #(
      .N_SLAVES   (N_SLAVES),
      .ADDR_W     (ADDR_W),
      .BASE_ADDRS (BASE_ADDRS),
      .ADDR_MASKS (ADDR_MASKS)
   ) u_dec (
      .i_addr    (req_addr),
      .o_hit_vec (w_hit_vec),
      .o_hit     (w_hit)
   );

   // Acks from slaves other than the selected one never advance the FSM.
   assign w_ack = |(dev_ack & r_sel);

   always_comb begin
      w_sel_rdata = '0;
      for (int i = 0; i < N_SLAVES; i++) begin
         if (r_sel[i]) w_sel_rdata = w_sel_rdata | dev_rdata[i*DATA_W +: DATA_W];
      end
   end

`ifdef MMIO_BUS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_tmo_cnt;

   // Fires in the BUSY cycle whose increment brings the counter to the limit.
   assign w_tmo = (r_state == ST_BUSY) && !w_ack &&
                  (r_tmo_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_tmo_cnt <= '0;
      end else if (w_accept) begin
         r_tmo_cnt <= '0;
      end else if (r_state == ST_BUSY && !w_ack && r_tmo_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end
`else
   assign w_tmo = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = w_hit ? ST_BUSY : ST_RESP;
            end
         end
         ST_BUSY: if (w_ack || w_tmo) w_state_nxt = ST_RESP;
         ST_RESP: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_sel   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else if (w_accept) begin
         r_sel   <= w_hit_vec;
         r_we    <= req_we;
         r_addr  <= req_addr;
         r_wdata <= req_wdata;
         if (!w_hit) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
         end
      end else if (r_state == ST_BUSY && (w_ack || w_tmo)) begin
         r_sel   <= '0;
         r_rdata <= (w_ack && !r_we) ? w_sel_rdata : '0;
         r_err   <= !w_ack;
      end
   end

   assign rsp_valid = (r_state == ST_RESP);
   assign stall     = req_valid & ~rsp_valid;
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;
   assign dev_sel   = r_sel;
   assign dev_we    = r_we;
   assign dev_addr  = r_addr;
   assign dev_wdata = r_wdata;

endmodule

// File: tb/tb_mmio_bus_bridge.sv
// Scoreboarded random/directed bench for mmio_bus_bridge with an overlapping slot map.
module tb_mmio_bus_bridge;

   localparam int TMO = 16;
   // slot order 3..0: slot 3 overlaps slots 0 and 2 so priority is exercised
   localparam logic [127:0] TB_BASE = {32'h1001_0000, 32'h1001_0100, 32'h0040_0000, 32'h1001_0000};
   localparam logic [127:0] TB_MASK = {32'hFFFF_0000, 32'hFFFF_FFF0, 32'hFFFF_F000, 32'hFFFF_FF00};

   logic [31:0] ref_base [4] = '{32'h1001_0000, 32'h0040_0000, 32'h1001_0100, 32'h1001_0000};
   logic [31:0] ref_mask [4] = '{32'hFFFF_FF00, 32'hFFFF_F000, 32'hFFFF_FFF0, 32'hFFFF_0000};

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_we = 1'b0;
   logic [31:0]  req_addr = '0;
   logic [31:0]  req_wdata = '0;
   logic         stall;
   logic         rsp_valid;
   logic [31:0]  rsp_rdata;
   logic         rsp_err;
   logic [3:0]   dev_sel;
   logic         dev_we;
   logic [31:0]  dev_addr;
   logic [31:0]  dev_wdata;
   logic [127:0] dev_rdata = '0;
   logic [3:0]   dev_ack = '0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   mmio_bus_bridge #(
      .N_SLAVES       (4),
      .ADDR_W         (32),
      .DATA_W         (32),
      .BASE_ADDRS     (TB_BASE),
      .ADDR_MASKS     (TB_MASK),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .stall     (stall),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .dev_sel   (dev_sel),
      .dev_we    (dev_we),
      .dev_addr  (dev_addr),
      .dev_wdata (dev_wdata),
      .dev_rdata (dev_rdata),
      .dev_ack   (dev_ack)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int ref_slot(input logic [31:0] addr);
      for (int i = 0; i < 4; i++)
         if ((addr & ref_mask[i]) == ref_base[i]) return i;
      return -1;
   endfunction

   // Monitor: every response strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      chk("dev_sel_onehot", 64'($countones(dev_sel) <= 1), 64'd1);
      if (rsp_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp actual=rsp_valid expected=no response (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", rsp_err, e.err);
            chk("rsp_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic do_reset();
      rst = 1'b0;
      req_valid = 1'b0;
      dev_ack = '0;
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
   endtask

   task automatic wait_rsp();
      bit got = 0;
      for (int t = 0; t < 8 && !got; t++) begin
         if (rsp_valid) got = 1;
         else begin
            @(posedge clk); #1;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL rsp_timeout actual=no rsp_valid expected=rsp_valid (cycle %0d)", cyc);
         do_reset();
      end else begin
         chk("dev_sel_resp", dev_sel, 4'b0000);
         chk("stall_resp", stall, 1'b0);
         @(posedge clk); #1;
         req_valid = 1'b0;
      end
   endtask

   // spur: 0 none, 1 random acks on other slots, 2 acks on every other slot
   task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int k, input logic [31:0] sdata, input int spur);
      int         slot;
      int         acc;
      exp_t       e;
      logic [3:0] onehot;
      slot = ref_slot(addr);
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      dev_rdata = {$urandom, $urandom, $urandom, $urandom};
      acc       = cyc;
      e.cyc     = acc + ((slot < 0) ? 1 : k + 1);
      e.err     = (slot < 0);
      e.rdata   = (slot < 0 || we) ? 32'h0 : sdata;
      exp_q.push_back(e);
      if (slot >= 0) begin
         onehot = 4'b0001 << slot;
         for (int c = 1; c <= k; c++) begin
            @(posedge clk); #1;
            chk("dev_sel_busy", dev_sel, onehot);
            chk("dev_we_busy", dev_we, we);
            chk("dev_addr_busy", dev_addr, addr);
            chk("dev_wdata_busy", dev_wdata, wdata);
            chk("stall_busy", stall, 1'b1);
            if (spur == 2)      dev_ack = ~onehot;
            else if (spur == 1) dev_ack = 4'($urandom) & ~onehot;
            else                dev_ack = '0;
            if (c == k) begin
               dev_ack[slot] = 1'b1;
               dev_rdata[slot*32 +: 32] = sdata;
            end
         end
      end
      @(posedge clk); #1;
      dev_ack = '0;
      if (slot < 0) chk("dev_sel_unmapped", dev_sel, 4'b0000);
      wait_rsp();
   endtask

   task automatic run_noack(input logic [31:0] addr);
      int         slot;
      int         acc;
      logic [3:0] onehot;
      slot   = ref_slot(addr);
      onehot = 4'b0001 << slot;
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = addr;
      acc       = cyc;
`ifdef MMIO_BUS_TIMEOUT_EN
      begin
         exp_t e;
         e.cyc = acc + TMO + 1;
         e.err = 1'b1;
         e.rdata = 32'h0;
         exp_q.push_back(e);
      end
      for (int c = 1; c <= TMO; c++) begin
         @(posedge clk); #1;
         if (c == 1 || c == TMO) chk("dev_sel_tmo", dev_sel, onehot);
      end
      @(posedge clk); #1;
      chk("rsp_valid_tmo", rsp_valid, 1'b1);
      wait_rsp();
`else
      begin
         int stalled = 0;
         int rsps = 0;
         for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (stall) stalled++;
            if (rsp_valid) rsps++;
         end
         chk("stall_cycles_noack", stalled, 100);
         chk("rsp_count_noack", rsps, 0);
         chk("dev_sel_noack", dev_sel, onehot);
      end
      do_reset();
      chk("dev_sel_after_rst", dev_sel, 4'b0000);
`endif
   endtask

   task automatic run_reset_midbusy();
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 32'h1001_0104;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("dev_sel_pre_rst", dev_sel, 4'b0100);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_dev_sel", dev_sel, 4'b0000);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err", rsp_err, 1'b0);
      chk("rst_dev_we", dev_we, 1'b0);
      req_valid = 1'b0;
      rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sel", dev_sel, 4'b0000);
      chk("rst_we", dev_we, 1'b0);
      chk("rst_addr", dev_addr, 32'h0);
      chk("rst_wdata", dev_wdata, 32'h0);
      chk("rst_rvalid", rsp_valid, 1'b0);
      chk("rst_rdata", rsp_rdata, 32'h0);
      chk("rst_err", rsp_err, 1'b0);
      chk("rst_stall", stall, 1'b0);
      rst = 1'b1;

      run_txn(1'b0, 32'h1001_0004, 32'h0, 1, 32'hCAFE_0001, 0);
      run_txn(1'b1, 32'h1001_0100, 32'h0000_00A5, 3, 32'h1234_5678, 1);
      run_txn(1'b0, 32'h2000_0000, 32'h0, 1, 32'hDEAD_BEEF, 0);
      run_txn(1'b0, 32'h1001_0008, 32'h0, 3, 32'h0BAD_F00D, 2);
      run_txn(1'b0, 32'h1001_0300, 32'h0, 2, 32'h3333_0003, 1);
      run_txn(1'b0, 32'h0040_0ABC, 32'h0, 2, 32'h0440_0ABC, 1);
      run_noack(32'h1001_0200);
      run_txn(1'b0, 32'h1001_0010, 32'h0, 1, 32'h5A5A_0010, 0);
      run_reset_midbusy();
      run_txn(1'b0, 32'h1001_0104, 32'h0, 2, 32'h7777_0104, 0);

      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 5))
            0:       a = 32'h1001_0000 + $urandom_range(0, 255);
            1:       a = 32'h0040_0000 + $urandom_range(0, 4095);
            2:       a = 32'h1001_0100 + $urandom_range(0, 15);
            3:       a = 32'h1001_0000 + $urandom_range(0, 65535);
            4:       a = 32'h1001_0200 + $urandom_range(0, 15);
            default: a = $urandom;
         endcase
         run_txn(1'($urandom), a, $urandom, $urandom_range(1, 5), $urandom, $urandom_range(0, 2));
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
